// File: rtl/shared_cache_arbiter.sv
// shared_cache_arbiter: round-robin arbiter that funnels NUM_CORES core
// requests onto one shared cache port, one transaction at a time.
// Optional feature: define ARB_TIMEOUT_EN to add a BUSY watchdog that aborts
// a transaction after TIMEOUT cycles without cache_ack (core_err=1).
module shared_cache_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [2*NUM_CORES-1:0]      core_rw,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_gnt,
   output logic [NUM_CORES-1:0]        core_done,
   output logic [DATA_W-1:0]           core_rdata,
   output logic                        core_hit,
   output logic                        core_err,
   output logic                        cache_valid,
   output logic [1:0]                  cache_rw,
   output logic [ADDR_W-1:0]           cache_addr,
   output logic [DATA_W-1:0]           cache_wdata,
   input  logic                        cache_ack,
   input  logic [DATA_W-1:0]           cache_rdata,
   input  logic                        cache_hit
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   // Elaboration-time parameter sanity check
   if (NUM_CORES < 2 || NUM_CORES > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("shared_cache_arbiter: NUM_CORES must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [IDX_W-1:0]       sel_q, sel_d;
   logic [NUM_CORES-1:0]   gnt_q, gnt_d;
   logic [NUM_CORES-1:0]   done_q, done_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic                   hit_q, hit_d;
   logic                   cvalid_q, cvalid_d;
   logic [1:0]             crw_q, crw_d;
   logic [ADDR_W-1:0]      caddr_q, caddr_d;
   logic [DATA_W-1:0]      cwdata_q, cwdata_d;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
`endif

   logic [IDX_W-1:0]       pick;
   logic [IDX_W-1:0]       cand;
   logic                   found;

   // Rotating-priority search: first requester upward from last_grant+1
   always_comb begin
      pick  = last_q;
      cand  = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_CORES; i++) begin
         cand = IDX_W'((int'(last_q) + i) % NUM_CORES);
         if (!found && core_req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      sel_d    = sel_q;
      gnt_d    = '0;
      done_d   = '0;
      rdata_d  = rdata_q;
      hit_d    = hit_q;
      cvalid_d = cvalid_q;
      crw_d    = crw_q;
      caddr_d  = caddr_q;
      cwdata_d = cwdata_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = BUSY;
               sel_d       = pick;
               last_d      = pick;
               gnt_d[pick] = 1'b1;
               cvalid_d    = 1'b1;
               crw_d       = core_rw[2*int'(pick) +: 2];
               caddr_d     = core_addr[int'(pick)*ADDR_W +: ADDR_W];
               cwdata_d    = core_wdata[int'(pick)*DATA_W +: DATA_W];
`ifdef ARB_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         BUSY: begin
            if (cache_ack) begin
               state_d       = DONE;
               cvalid_d      = 1'b0;
               rdata_d       = cache_rdata;
               hit_d         = cache_hit;
               done_d[sel_q] = 1'b1;
`ifdef ARB_TIMEOUT_EN
               err_d         = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // Watchdog expiry: abort with an error completion
               state_d       = DONE;
               cvalid_d      = 1'b0;
               rdata_d       = '0;
               hit_d         = 1'b0;
               err_d         = 1'b1;
               done_d[sel_q] = 1'b1;
            end else begin
               cnt_d         = cnt_q + 1'b1;
`endif
            end
         end
         DONE: begin
            // Completion data is only meaningful during the done pulse
            state_d = IDLE;
            rdata_d = '0;
            hit_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset makes core 0 the first priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= IDX_W'(NUM_CORES - 1);
         sel_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         rdata_q  <= '0;
         hit_q    <= 1'b0;
         cvalid_q <= 1'b0;
         crw_q    <= '0;
         caddr_q  <= '0;
         cwdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         sel_q    <= sel_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         hit_q    <= hit_d;
         cvalid_q <= cvalid_d;
         crw_q    <= crw_d;
         caddr_q  <= caddr_d;
         cwdata_q <= cwdata_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign core_gnt    = gnt_q;
   assign core_done   = done_q;
   assign core_rdata  = rdata_q;
   assign core_hit    = hit_q;
   assign cache_valid = cvalid_q;
   assign cache_rw    = crw_q;
   assign cache_addr  = caddr_q;
   assign cache_wdata = cwdata_q;
`ifdef ARB_TIMEOUT_EN
   assign core_err    = err_q;
`else
   assign core_err    = 1'b0;
`endif

endmodule

// File: tb/tb_shared_cache_arbiter.sv
// Scoreboard bench for shared_cache_arbiter: stimulus pushes expected grant
// and done events; a negedge monitor pops and compares them.
module tb_shared_cache_arbiter;
   localparam int NC = 4;
   localparam int AW = 12;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NC-1:0]   core_req = '0;
   logic [2*NC-1:0] core_rw = '0;
   logic [NC*AW-1:0] core_addr = '0;
   logic [NC*DW-1:0] core_wdata = '0;
   logic [NC-1:0]   core_gnt, core_done;
   logic [DW-1:0]   core_rdata;
   logic            core_hit, core_err;
   logic            cache_valid;
   logic [1:0]      cache_rw;
   logic [AW-1:0]   cache_addr;
   logic [DW-1:0]   cache_wdata;
   logic            cache_ack = 1'b0;
   logic [DW-1:0]   cache_rdata = '0;
   logic            cache_hit = 1'b0;

   shared_cache_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .core_req(core_req), .core_rw(core_rw),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
      .core_done(core_done), .core_rdata(core_rdata), .core_hit(core_hit),
      .core_err(core_err), .cache_valid(cache_valid), .cache_rw(cache_rw),
      .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_ack(cache_ack),
      .cache_rdata(cache_rdata), .cache_hit(cache_hit));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct {
      bit         is_done;
      int         idx;
      logic [1:0] rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic       hit;
      logic       err;
   } exp_t;
   exp_t q[$];

   // Per-core input tables (rw codes include 00 and 11 to check pass-through)
   logic [1:0]    rw_tab[NC]    = '{2'b01, 2'b10, 2'b00, 2'b11};
   logic [AW-1:0] addr_tab[NC]  = '{12'h100, 12'h101, 12'h102, 12'h103};
   logic [DW-1:0] wdata_tab[NC] = '{8'h40, 8'h41, 8'h42, 8'h43};

   task automatic load_inputs();
      for (int k = 0; k < NC; k++) begin
         core_rw[2*k +: 2]     = rw_tab[k];
         core_addr[k*AW +: AW] = addr_tab[k];
         core_wdata[k*DW +: DW] = wdata_tab[k];
      end
   endtask

   task automatic push_gnt(input int k);
      exp_t e;
      e = '{is_done: 1'b0, idx: k, rw: rw_tab[k], addr: addr_tab[k],
            wdata: wdata_tab[k], rdata: '0, hit: 1'b0, err: 1'b0};
      q.push_back(e);
   endtask

   task automatic push_done(input int k, input logic [DW-1:0] rd, input logic h, input logic er);
      exp_t e;
      e = '{is_done: 1'b1, idx: k, rw: '0, addr: '0, wdata: '0, rdata: rd, hit: h, err: er};
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int k, input int lim);
      int n = 0;
      while (!core_gnt[k] && n < lim) begin tick(); n++; end
      chk($sformatf("gnt%0d_seen", k), 32'(core_gnt[k]), 1);
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (core_done == '0 && n < lim) begin tick(); n++; end
      chk("done_seen", 32'(core_done != '0), 1);
   endtask

   // Acknowledge the current BUSY transaction in the next edge
   task automatic ack(input logic [DW-1:0] rd, input logic h);
      cache_ack = 1'b1; cache_rdata = rd; cache_hit = h;
      tick();
      cache_ack = 1'b0; cache_rdata = 8'hEE; cache_hit = 1'b0;
   endtask

   // Monitor: compare every grant/done pulse against the scoreboard
   exp_t m;
   always @(negedge clk) begin
      if ($countones(core_gnt) + $countones(core_done) > 1)
         chk("onehot", 32'($countones(core_gnt) + $countones(core_done)), 1);
      if (core_gnt != '0) begin
         chk("gnt_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            m = q.pop_front();
            chk("gnt_kind", 32'(m.is_done), 0);
            chk("gnt_vec", 32'(core_gnt), 32'(4'b0001 << m.idx));
            chk("gnt_cache_valid", 32'(cache_valid), 1);
            chk("gnt_cache_rw", 32'(cache_rw), 32'(m.rw));
            chk("gnt_cache_addr", 32'(cache_addr), 32'(m.addr));
            chk("gnt_cache_wdata", 32'(cache_wdata), 32'(m.wdata));
         end
      end
      if (core_done != '0) begin
         chk("done_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            m = q.pop_front();
            chk("done_kind", 32'(m.is_done), 1);
            chk("done_vec", 32'(core_done), 32'(4'b0001 << m.idx));
            chk("done_rdata", 32'(core_rdata), 32'(m.rdata));
            chk("done_hit", 32'(core_hit), 32'(m.hit));
            chk("done_err", 32'(core_err), 32'(m.err));
            chk("done_cache_valid", 32'(cache_valid), 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int d_cyc, g_cyc;

   initial begin
      // Reset state
      load_inputs();
      rst = 1'b1;
      tick(); tick();
      chk("rst_gnt", 32'(core_gnt), 0);
      chk("rst_done", 32'(core_done), 0);
      chk("rst_valid", 32'(cache_valid), 0);
      chk("rst_addr", 32'(cache_addr), 0);
      chk("rst_rdata_err", 32'({core_rdata, core_hit, core_err}), 0);
      rst = 1'b0;
      tick();

      // Single read from core 0 at 0x123
      addr_tab[0] = 12'h123; wdata_tab[0] = 8'h11;
      load_inputs();
      push_gnt(0);
      push_done(0, 8'hA5, 1'b1, 1'b0);
      core_req = 4'b0001;
      tick();
      chk("t1_gnt_next_cycle", 32'(core_gnt), 32'h1);
      chk("t1_cache_addr", 32'(cache_addr), 32'h123);
      core_req = '0;
      ack(8'hA5, 1'b1);
      chk("t1_done_next_cycle", 32'(core_done), 32'h1);
      tick(); tick();

      // cache_ack while IDLE must be ignored
      cache_ack = 1'b1;
      tick();
      cache_ack = 1'b0;
      tick();
      chk("idle_ack_no_done", 32'(core_done), 0);
      chk("idle_ack_no_valid", 32'(cache_valid), 0);

      // All cores requesting: order 0,1,2,3,0,1,2,3 from reset priority
      rst = 1'b1; tick(); rst = 1'b0;
      addr_tab[0] = 12'h100; wdata_tab[0] = 8'h40;
      load_inputs();
      for (int t = 0; t < 8; t++) begin
         push_gnt(t % NC);
         push_done(t % NC, 8'(8'h30 + t), 1'(t % 2), 1'b0);
      end
      core_req = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         wait_gnt(t % NC, 10);
         ack(8'(8'h30 + t), 1'(t % 2));
         if (t == 7) core_req = '0;
      end
      tick(); tick();

      // Core 2 arrives while core 1 is BUSY; grant 2 cycles after done
      push_gnt(1); push_done(1, 8'h5A, 1'b0, 1'b0);
      push_gnt(2); push_done(2, 8'h77, 1'b1, 1'b0);
      core_req = 4'b0010;
      wait_gnt(1, 10);
      core_req = 4'b0100;
      tick(); tick();
      chk("busy_no_regrant", 32'(core_gnt), 0);
      ack(8'h5A, 1'b0);
      d_cyc = cyc;
      wait_gnt(2, 10);
      chk("gnt_gap_after_done", 32'(cyc - d_cyc), 2);
      core_req = '0;
      ack(8'h77, 1'b1);
      tick(); tick();

      // Reset two cycles into BUSY aborts silently; core 0 then first
      push_gnt(1);
      core_req = 4'b0010;
      wait_gnt(1, 10);
      core_req = '0;
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(cache_valid), 0);
      chk("mid_rst_outs", 32'({core_gnt, core_done, core_rdata, core_hit, core_err}), 0);
      chk("mid_rst_cache", 32'({cache_rw, cache_addr, cache_wdata}), 0);
      rst = 1'b0;
      push_gnt(0); push_done(0, 8'h01, 1'b0, 1'b0);
      push_gnt(3); push_done(3, 8'h03, 1'b1, 1'b0);
      core_req = 4'b1001;
      wait_gnt(0, 10);
      core_req = 4'b1000;
      ack(8'h01, 1'b0);
      wait_gnt(3, 10);
      core_req = '0;
      ack(8'h03, 1'b1);
      tick(); tick();

`ifdef ARB_TIMEOUT_EN
      // No ack: watchdog completes core 2 with err after 15 BUSY cycles
      push_gnt(2); push_done(2, 8'h00, 1'b0, 1'b1);
      push_gnt(3); push_done(3, 8'h9C, 1'b1, 1'b0);
      cache_rdata = 8'hFF; cache_hit = 1'b1;
      core_req = 4'b1100;
      wait_gnt(2, 10);
      g_cyc = cyc;
      core_req = 4'b1000;
      wait_done(40);
      chk("timeout_latency", 32'(cyc - g_cyc), 15);
      chk("timeout_err", 32'(core_err), 1);
      wait_gnt(3, 10);
      core_req = '0;
      ack(8'h9C, 1'b1);
      tick(); tick();
`endif

      chk("scoreboard_empty", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
